// File: rtl/cella_pkg.sv
// cella_pkg
//   Shared definitions for the CAM/MAC array row-path sequencer:
//   command op codes, FSM state encoding, command field widths and the
//   packed command record, plus the row-mask scan helper.
//   Imported with: import cella_pkg::*;

package cella_pkg;

    localparam int OP_W   = 2;
    localparam int ADDR_W = 2;
    localparam int DATA_W = 4;
    localparam int ROWS   = 4;
    localparam int CMD_W  = OP_W + ADDR_W + DATA_W;

    typedef enum logic [OP_W-1:0] {
        OP_WRITE   = 2'b00,
        OP_SEARCH  = 2'b01,
        OP_MAC     = 2'b10,
        OP_MAC_BAR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRE   = 2'd1,
        ST_EVAL  = 2'd2,
        ST_SENSE = 2'd3
    } state_e;

    typedef struct packed {
        op_e               op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    // Lowest row >= from whose mask bit is set. Returns {found, row}.
    // from is one bit wider than a row index so "past the last row" (4)
    // is representable and the scan can never wrap back to row 0.
    function automatic logic [2:0] find_row(input logic [ROWS-1:0] mask,
                                            input logic [2:0]      from);
        logic [2:0] r;
        r = 3'b000;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= from)) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

    function automatic logic is_mac(input op_e op);
        return (op == OP_MAC) || (op == OP_MAC_BAR);
    endfunction

endpackage

// File: rtl/cella_array_ctrl_fifo.sv
// cella_cmd_fifo
//   Two-entry command queue, valid/ready on both sides. A push into a full
//   queue is accepted when a pop happens on the same edge, so in_ready
//   looks through to out_ready.
//   Ports:
//     clk, rst_n                    clock, synchronous active-low reset
//     in_valid/in_ready/in_data     write side (command bus)
//     out_valid/out_ready/out_data  read side (sequencer)

module cella_cmd_fifo
    import cella_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CMD_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CMD_W-1:0] out_data
);

    logic [CMD_W-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign in_ready  = (count != 2'd2) || out_ready;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/cella_array_ctrl.sv
// cella_array_ctrl
//   Op sequencer for the CAM/MAC array row path. Takes commands over
//   valid/ready and drives the row decoder through precharge -> evaluate ->
//   sense, once per row pass. MAC ops sweep the row mask in ascending order.
//   Optional feature macro: CELLA_CMD_FIFO_EN (2-entry command queue,
//   back-to-back commands without an IDLE cycle). Default build: one
//   command at a time, accepted only in IDLE.
//   Ports:
//     clk, rst_n                  clock, synchronous active-low reset
//     cmd_valid/cmd_ready         command handshake
//     cmd_op, cmd_addr, cmd_data  op code, WRITE row, data/key/row mask
//     preb, cs, w_en, MAC_en,
//     read_bar, addr, data        row decoder controls (registered)
//     sense_en                    one-cycle sense strobe per row pass
//     row_idx                     row of the current pass
//     done                        one-cycle command-complete pulse
//     busy                        high in any state but IDLE
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | array parked: cs=0, preb=0, controls 0; waiting for a cmd
//   ST_PRE   | precharge (preb=0), cs=1, controls set for the pass
//   ST_EVAL  | evaluate (preb=1), controls held
//   ST_SENSE | one cycle, sense_en=1; next masked row, next cmd or IDLE

module cella_array_ctrl
    import cella_pkg::*;
#(
    parameter int PRE_CYCLES  = 1,
    parameter int EVAL_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              preb,
    output logic              cs,
    output logic              w_en,
    output logic              MAC_en,
    output logic              read_bar,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              sense_en,
    output logic [ADDR_W-1:0] row_idx,
    output logic              done,
    output logic              busy
);

    localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(PRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] EVAL_LOAD = CNT_W'(EVAL_CYCLES - 1);

    state_e            state;
    logic [CNT_W-1:0]  phase_cnt;
    op_e               cur_op;
    logic [DATA_W-1:0] cur_mask;
    logic              live;

    cmd_t              src_cmd;
    logic              src_valid;
    logic              take;

    logic [2:0]        nxt_row;
    logic [2:0]        first_row;
    logic              more_rows;
    logic              start_empty;
    logic [ADDR_W-1:0] start_row;

    // ------------------------------------------------------------------
    // Command source
    // ------------------------------------------------------------------
`ifdef CELLA_CMD_FIFO_EN
    logic fifo_in_ready;

    cella_cmd_fifo u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (cmd_valid && live),
        .in_ready  (fifo_in_ready),
        .in_data   ({cmd_op, cmd_addr, cmd_data}),
        .out_valid (src_valid),
        .out_ready (take),
        .out_data  (src_cmd)
    );

    // live keeps ready low for the cycle reset is held.
    assign cmd_ready = live && fifo_in_ready;
    // Chain straight from the last SENSE into the next queued command.
    assign take      = src_valid &&
                       ((state == ST_IDLE) || ((state == ST_SENSE) && !more_rows));
`else
    assign cmd_ready = live && (state == ST_IDLE);
    assign src_valid = cmd_valid && cmd_ready;
    assign src_cmd   = cmd_t'({cmd_op, cmd_addr, cmd_data});
    assign take      = src_valid;
`endif

    // ------------------------------------------------------------------
    // Row scan and first-pass set-up for an incoming command
    // ------------------------------------------------------------------
    always_comb begin
        nxt_row     = find_row(cur_mask, {1'b0, row_idx} + 3'd1);
        more_rows   = is_mac(cur_op) && nxt_row[2];
        first_row   = find_row(src_cmd.data, 3'd0);
        start_empty = is_mac(src_cmd.op) && !first_row[2];
        case (src_cmd.op)
            OP_WRITE:  start_row = src_cmd.addr;
            OP_SEARCH: start_row = '0;
            default:   start_row = first_row[1:0];
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer FSM, all outputs registered
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            phase_cnt <= '0;
            cur_op    <= OP_WRITE;
            cur_mask  <= '0;
            live      <= 1'b0;
            preb      <= 1'b0;
            cs        <= 1'b0;
            w_en      <= 1'b0;
            MAC_en    <= 1'b0;
            read_bar  <= 1'b0;
            addr      <= '0;
            data      <= '0;
            sense_en  <= 1'b0;
            row_idx   <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            live     <= 1'b1;
            sense_en <= 1'b0;
            done     <= 1'b0;

            case (state)
                ST_IDLE: begin
                end

                ST_PRE: begin
                    if (phase_cnt == '0) begin
                        state     <= ST_EVAL;
                        phase_cnt <= EVAL_LOAD;
                        preb      <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end

                ST_EVAL: begin
                    if (phase_cnt == '0) begin
                        state    <= ST_SENSE;
                        sense_en <= 1'b1;
                        done     <= !more_rows;
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end

                ST_SENSE: begin
                    if (more_rows) begin
                        state     <= ST_PRE;
                        phase_cnt <= PRE_LOAD;
                        preb      <= 1'b0;
                        addr      <= nxt_row[1:0];
                        row_idx   <= nxt_row[1:0];
                    end else begin
                        // Park the array: cs and preb drop on the same edge.
                        state    <= ST_IDLE;
                        preb     <= 1'b0;
                        cs       <= 1'b0;
                        w_en     <= 1'b0;
                        MAC_en   <= 1'b0;
                        read_bar <= 1'b0;
                        addr     <= '0;
                        data     <= '0;
                        row_idx  <= '0;
                        busy     <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    preb  <= 1'b0;
                    cs    <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase

            // A new command overrides whatever the case above decided; it
            // only happens from IDLE or from the final SENSE.
            if (take) begin
                cur_op   <= src_cmd.op;
                cur_mask <= src_cmd.data;
                if (start_empty) begin
                    // Empty MAC mask: no array activity, just complete.
                    state    <= ST_IDLE;
                    done     <= 1'b1;
                    preb     <= 1'b0;
                    cs       <= 1'b0;
                    w_en     <= 1'b0;
                    MAC_en   <= 1'b0;
                    read_bar <= 1'b0;
                    addr     <= '0;
                    data     <= '0;
                    row_idx  <= '0;
                    busy     <= 1'b0;
                end else begin
                    state     <= ST_PRE;
                    phase_cnt <= PRE_LOAD;
                    preb      <= 1'b0;
                    cs        <= 1'b1;
                    w_en      <= (src_cmd.op == OP_WRITE);
                    MAC_en    <= is_mac(src_cmd.op);
                    read_bar  <= (src_cmd.op == OP_MAC_BAR);
                    addr      <= start_row;
                    row_idx   <= start_row;
                    data      <= src_cmd.data;
                    busy      <= 1'b1;
                end
            end
        end
    end

endmodule
